// File: rtl/uint32_rcv.sv
`timescale 1ns/1ps
// Purpose : receive side of the multiplexed 8-digit 7-segment bus; decodes digits back into a 32-bit word.
// Latency : digit 7 on the pins in cycle t -> valid in cycle t + SYNC_STAGES + STABLE_CYCLES.
// Backpr. : none; the panel bus cannot be stalled, and bad or out-of-order digits raise 1-cycle error pulses.
module uint32_rcv #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  drains,
    input  logic [7:0]  leds,
    output logic [31:0] data,
    output logic [7:0]  dots,
    output logic        valid,
    output logic        seq_err,
    output logic        seg_err,
    output logic        onehot_err
);

    typedef enum logic [0:0] {IDLE, COLLECT} state_t;

    localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

    // {drains, leds} as seen after the synchroniser.
    logic [15:0] samp;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign samp = {drains, leds};
        end else begin : g_sync
            logic [15:0] sync_q [SYNC_STAGES];
            logic [15:0] sync_d [SYNC_STAGES];

            // Shift the raw pins through the synchroniser chain.
            always_comb begin
                sync_d[0] = {drains, leds};
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    sync_d[i] = sync_q[i-1];
                end
            end

            // Synchroniser flops.
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
                end else begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
                end
            end

            assign samp = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [15:0] prev_q, prev_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        accept;

    // Run-length counter. A sample is accepted exactly once, on the cycle its run reaches STABLE_N.
    always_comb begin
        prev_d = samp;
        if (samp != prev_q)       cnt_d = 8'd1;
        else if (cnt_q >= STABLE_N) cnt_d = STABLE_N;
        else                      cnt_d = cnt_q + 8'd1;
        accept = (cnt_d == STABLE_N) && ((cnt_q != STABLE_N) || (samp != prev_q));
    end

    logic [7:0] s_dr;
    logic [7:0] s_led;
    logic       blank;
    logic       multi;
    logic [2:0] dig;
    logic [3:0] nib;
    logic       hit;

    assign s_dr  = samp[15:8];
    assign s_led = samp[7:0];
    assign blank = (s_dr == 8'd0);
    assign multi = ((s_dr & (s_dr - 8'd1)) != 8'd0);

    // Digit index from the one-hot strobe, and the reverse hex lookup on segments a..g.
    always_comb begin
        dig = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (s_dr[i]) dig = 3'(i);
        end
        hit = 1'b1;
        nib = 4'h0;
        case (s_led[6:0])
            7'h3F: nib = 4'h0;
            7'h06: nib = 4'h1;
            7'h5B: nib = 4'h2;
            7'h4F: nib = 4'h3;
            7'h66: nib = 4'h4;
            7'h6D: nib = 4'h5;
            7'h7D: nib = 4'h6;
            7'h07: nib = 4'h7;
            7'h7F: nib = 4'h8;
            7'h6F: nib = 4'h9;
            7'h77: nib = 4'hA;
            7'h7C: nib = 4'hB;
            7'h39: nib = 4'hC;
            7'h5E: nib = 4'hD;
            7'h79: nib = 4'hE;
            7'h71: nib = 4'hF;
            default: hit = 1'b0;
        endcase
    end

    state_t      state_q, state_d;
    logic [2:0]  exp_q, exp_d;
    logic        bad_q, bad_d;
    logic [31:0] shadow_q, shadow_d;
    logic [7:0]  sdots_q, sdots_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  dots_q, dots_d;
    logic        valid_q, valid_d;
    logic        seq_err_q, seq_err_d;
    logic        seg_err_q, seg_err_d;
    logic        onehot_err_q, onehot_err_d;

    // Frame FSM: collects digits 0..7 in order into the shadow word and publishes clean frames.
    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        bad_d        = bad_q;
        shadow_d     = shadow_q;
        sdots_d      = sdots_q;
        data_d       = data_q;
        dots_d       = dots_q;
        valid_d      = 1'b0;
        seq_err_d    = 1'b0;
        seg_err_d    = 1'b0;
        onehot_err_d = 1'b0;

        if (accept) begin
            if (blank) begin
                // Transmitter output-enable dropped: abandon the frame quietly.
                state_d = IDLE;
            end else if (multi) begin
                onehot_err_d = 1'b1;
                state_d      = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (dig == 3'd0) begin
                            shadow_d[{dig, 2'b00} +: 4] = nib;
                            sdots_d[dig]                = s_led[7];
                            bad_d                       = !hit;
                            seg_err_d                   = !hit;
                            exp_d                       = 3'd1;
                            state_d                     = COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (dig == exp_q) begin
                            shadow_d[{dig, 2'b00} +: 4] = nib;
                            sdots_d[dig]                = s_led[7];
                            seg_err_d                   = !hit;
                            bad_d                       = bad_q | !hit;
                            exp_d                       = exp_q + 3'd1;
                            if (dig == 3'd7) begin
                                state_d = IDLE;
                                if (!bad_d) begin
                                    valid_d = 1'b1;
                                    data_d  = shadow_d;
                                    dots_d  = sdots_d;
                                end
                            end
                        end else begin
                            // Out of order. A fresh digit 0 restarts the frame instead of waiting.
                            seq_err_d = 1'b1;
                            if (dig == 3'd0) begin
                                shadow_d[{dig, 2'b00} +: 4] = nib;
                                sdots_d[dig]                = s_led[7];
                                bad_d                       = !hit;
                                exp_d                       = 3'd1;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // State, stability tracker and output registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prev_q       <= '0;
            cnt_q        <= '0;
            state_q      <= IDLE;
            exp_q        <= '0;
            bad_q        <= 1'b0;
            shadow_q     <= '0;
            sdots_q      <= '0;
            data_q       <= '0;
            dots_q       <= '0;
            valid_q      <= 1'b0;
            seq_err_q    <= 1'b0;
            seg_err_q    <= 1'b0;
            onehot_err_q <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            exp_q        <= exp_d;
            bad_q        <= bad_d;
            shadow_q     <= shadow_d;
            sdots_q      <= sdots_d;
            data_q       <= data_d;
            dots_q       <= dots_d;
            valid_q      <= valid_d;
            seq_err_q    <= seq_err_d;
            seg_err_q    <= seg_err_d;
            onehot_err_q <= onehot_err_d;
        end
    end

    assign data       = data_q;
    assign dots       = dots_q;
    assign valid      = valid_q;
    assign seq_err    = seq_err_q;
    assign seg_err    = seg_err_q;
    assign onehot_err = onehot_err_q;

endmodule
